// File: rtl/coproc_arb_pkg.sv
// rtl/coproc_arb_pkg.sv - shared state type, requester indices and default widths for the coprocessor bus arbiter
package coproc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic REQ_SPI = 1'b0;
    localparam logic REQ_CPU = 1'b1;

    localparam int DEF_AW          = 16;
    localparam int DEF_DW          = 32;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/coproc_arb_rr.sv
// rtl/coproc_arb_rr.sv - combinational two-way round-robin picker with lock override
module coproc_arb_rr
    import coproc_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    input  logic       lock_owner,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req;
        // An active lock masks the other requester out entirely
        if (lock) begin
            eligible = req & ((lock_owner == REQ_CPU) ? 2'b10 : 2'b01);
        end
        gnt_valid = |eligible;
        gnt_idx   = (eligible == 2'b11) ? ~last : eligible[1];
    end

endmodule

// File: rtl/coproc_bus_arbiter.sv
// rtl/coproc_bus_arbiter.sv - shares one coprocessor slave between SPI bridge and CPU; optional watchdog via COPROC_ARB_TIMEOUT_EN
module coproc_bus_arbiter
    import coproc_arb_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic            i_clk,
    input  logic            i_clr_n,
    input  logic [1:0]      i_req,
    input  logic [1:0]      i_we,
    input  logic [2*AW-1:0] i_addr,
    input  logic [2*DW-1:0] i_wdata,
    input  logic [1:0]      i_lock,
    output logic [1:0]      o_ack,
    output logic [1:0]      o_rvalid,
    output logic [1:0]      o_err,
    output logic [DW-1:0]   o_rdata,
    output logic            o_m_valid,
    output logic            o_m_we,
    output logic [AW-1:0]   o_m_addr,
    output logic [DW-1:0]   o_m_wdata,
    input  logic            i_m_ready,
    input  logic            i_m_rvalid,
    input  logic [DW-1:0]   i_m_rdata,
    output logic            o_owner,
    output logic            o_busy
);

    arb_state_t state, state_nx;
    logic       last, lock_flag;
    logic       gnt_valid, gnt_idx, grant;
    logic       expired, timeout;
    logic       rdata_ld, rdata_clr;
    logic [1:0] ack_nx, rvalid_nx, err_nx;

    coproc_arb_rr u_rr (
        .req        (i_req),
        .last       (last),
        .lock       (lock_flag & i_lock[o_owner]),
        .lock_owner (o_owner),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

`ifdef COPROC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;

    // Restarts on every entry to CMD or RESP, so each phase gets its own budget
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            wait_cnt <= '0;
        end else if (state == IDLE || state_nx != state) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expired = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign expired            = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        ack_nx    = 2'b00;
        rvalid_nx = 2'b00;
        err_nx    = 2'b00;
        rdata_ld  = 1'b0;
        rdata_clr = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    grant    = 1'b1;
                    state_nx = CMD;
                end
            end
            CMD: begin
                if (i_m_ready) begin
                    ack_nx[o_owner] = 1'b1;
                    state_nx        = o_m_we ? IDLE : RESP;
                end else if (expired) begin
                    ack_nx[o_owner] = 1'b1;
                    err_nx[o_owner] = 1'b1;
                    state_nx        = IDLE;
                end
            end
            RESP: begin
                if (i_m_rvalid) begin
                    rvalid_nx[o_owner] = 1'b1;
                    rdata_ld           = 1'b1;
                    state_nx           = IDLE;
                end else if (expired) begin
                    rvalid_nx[o_owner] = 1'b1;
                    err_nx[o_owner]    = 1'b1;
                    rdata_clr          = 1'b1;
                    state_nx           = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign timeout = |err_nx;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            o_ack     <= 2'b00;
            o_rvalid  <= 2'b00;
            o_err     <= 2'b00;
            o_rdata   <= '0;
            o_m_we    <= 1'b0;
            o_m_addr  <= '0;
            o_m_wdata <= '0;
            o_owner   <= REQ_SPI;
            last      <= REQ_CPU;
            lock_flag <= 1'b0;
        end else begin
            o_ack    <= ack_nx;
            o_rvalid <= rvalid_nx;
            o_err    <= err_nx;
            if (grant) begin
                o_m_we    <= i_we[gnt_idx];
                o_m_addr  <= gnt_idx ? i_addr[2*AW-1:AW] : i_addr[AW-1:0];
                o_m_wdata <= gnt_idx ? i_wdata[2*DW-1:DW] : i_wdata[DW-1:0];
                o_owner   <= gnt_idx;
                last      <= gnt_idx;
                lock_flag <= i_lock[gnt_idx];
            end else if (timeout || (state == IDLE && !i_lock[o_owner])) begin
                lock_flag <= 1'b0;
            end
            if (rdata_ld) begin
                o_rdata <= i_m_rdata;
            end else if (rdata_clr) begin
                o_rdata <= '0;
            end
        end
    end

    assign o_m_valid = (state == CMD);
    assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_coproc_bus_arbiter.sv
// tb/tb_coproc_bus_arbiter.sv - randomized scoreboard bench plus directed read, lock, reset and watchdog scenarios
module tb_coproc_bus_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int TO    = 8;
    localparam int NT    = 40;
    localparam int LIMIT = 20000;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          lock;
    } txn_t;

    logic            clk = 1'b0;
    logic            clr_n;
    logic [1:0]      req, we, lock;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      ack, rvalid, err;
    logic [DW-1:0]   rdata;
    logic            m_valid, m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_ready, m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            owner, busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    coproc_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .i_clk      (clk),
        .i_clr_n    (clr_n),
        .i_req      (req),
        .i_we       (we),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .i_lock     (lock),
        .o_ack      (ack),
        .o_rvalid   (rvalid),
        .o_err      (err),
        .o_rdata    (rdata),
        .o_m_valid  (m_valid),
        .o_m_we     (m_we),
        .o_m_addr   (m_addr),
        .o_m_wdata  (m_wdata),
        .i_m_ready  (m_ready),
        .i_m_rvalid (m_rvalid),
        .i_m_rdata  (m_rdata),
        .o_owner    (owner),
        .o_busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n    = 1'b0;
        req      = 2'b00;
        we       = 2'b00;
        lock     = 2'b00;
        addr     = '0;
        wdata    = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        tick();
        tick();
        check_eq("reset_ctl", {ack, rvalid, err, m_valid, m_we, owner, busy, m_addr}, 64'd0);
        check_eq("reset_data", {rdata, m_wdata}, 64'd0);
        clr_n = 1'b1;
    endtask

    txn_t          txq[2][$];
    txn_t          t, h, cur;
    logic [DW-1:0] mem[16];
    logic [DW-1:0] exp_rd;
    logic [1:0]    exp_ack, exp_rv, seen, active, cand;
    logic          own_m, last_m, lkf, w, exp_grant;
    int            phase, nphase, rdy_wait, rv_wait, cyc;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < NT; k++) begin
                t.we    = (k == 0) ? 1'b1 : 1'($urandom % 2);
                t.addr  = AW'($urandom_range(0, 15));
                t.wdata = $urandom;
                t.lock  = (k != 0) && ($urandom % 4 == 0);
                txq[n].push_back(t);
            end
        end
        active    = 2'b11;
        phase     = 0;
        last_m    = 1'b1;
        own_m     = 1'b0;
        lkf       = 1'b0;
        exp_ack   = 2'b00;
        exp_rv    = 2'b00;
        exp_rd    = '0;
        exp_grant = 1'b0;
        rdy_wait  = 0;
        rv_wait   = 0;
        do_reset();

        // Transaction-level model: who should win each idle slot, what the slave must see, what each master gets back
        cyc = 0;
        while ((txq[0].size() + txq[1].size() > 0 || phase != 0) && cyc < LIMIT) begin
            seen = exp_ack;
            for (int n = 0; n < 2; n++) begin
                if (seen[n]) begin
                    void'(txq[n].pop_front());
                    active[n] = (txq[n].size() > 0) && ($urandom % 3 != 0);
                end else if (!active[n] && txq[n].size() > 0 && $urandom % 3 == 0) begin
                    active[n] = 1'b1;
                end
                if (active[n]) begin
                    h                  = txq[n][0];
                    req[n]             = 1'b1;
                    we[n]              = h.we;
                    addr[n*AW +: AW]   = h.addr;
                    wdata[n*DW +: DW]  = h.wdata;
                    lock[n]            = h.lock;
                end else begin
                    req[n]             = 1'b0;
                    we[n]              = 1'($urandom % 2);
                    addr[n*AW +: AW]   = AW'($urandom);
                    wdata[n*DW +: DW]  = $urandom;
                    lock[n]            = 1'b0;
                end
            end

            exp_ack   = 2'b00;
            exp_rv    = 2'b00;
            exp_grant = 1'b0;
            m_ready   = 1'($urandom % 2);
            m_rvalid  = 1'($urandom % 2);
            m_rdata   = $urandom;
            nphase    = phase;
            case (phase)
                0: begin
                    cand = req;
                    if (lkf && lock[own_m]) cand = cand & (own_m ? 2'b10 : 2'b01);
                    if (cand != 2'b00) begin
                        w         = (cand == 2'b11) ? ~last_m : cand[1];
                        exp_grant = 1'b1;
                        own_m     = w;
                        last_m    = w;
                        lkf       = lock[w];
                        cur       = txq[w][0];
                        nphase    = 1;
                        rdy_wait  = $urandom_range(0, 3);
                    end else if (!lock[own_m]) begin
                        lkf = 1'b0;
                    end
                end
                1: begin
                    m_ready = (rdy_wait == 0);
                    if (m_ready) begin
                        exp_ack[own_m] = 1'b1;
                        if (cur.we) begin
                            mem[cur.addr[3:0]] = cur.wdata;
                            nphase = 0;
                        end else begin
                            nphase  = 2;
                            rv_wait = $urandom_range(0, 3);
                        end
                    end else begin
                        rdy_wait--;
                    end
                end
                default: begin
                    m_rvalid = (rv_wait == 0);
                    if (m_rvalid) begin
                        m_rdata       = mem[cur.addr[3:0]];
                        exp_rv[own_m] = 1'b1;
                        exp_rd        = m_rdata;
                        nphase        = 0;
                    end else begin
                        rv_wait--;
                    end
                end
            endcase
            phase = nphase;

            tick();
            check_eq("ack", ack, exp_ack);
            check_eq("rvalid", rvalid, exp_rv);
            check_eq("err", err, 2'b00);
            check_eq("rdata", rdata, exp_rd);
            check_eq("m_valid", m_valid, phase == 1);
            check_eq("busy", busy, phase != 0);
            check_eq("owner", owner, own_m);
            if (exp_grant) begin
                check_eq("m_we", m_we, cur.we);
                check_eq("m_addr", m_addr, cur.addr);
                check_eq("m_wdata", m_wdata, cur.wdata);
            end
            cyc++;
        end
        if (cyc >= LIMIT) check_eq("drain_budget", 1'b0, 1'b1);

        // CPU read: slave stalls 3 cycles, data 2 cycles after accept
        do_reset();
        req  = 2'b10;
        we   = 2'b00;
        addr = {16'h0010, 16'h0000};
        tick();
        check_eq("rd_grant", {m_valid, owner, m_addr}, {1'b1, 1'b1, 16'h0010});
        tick();
        tick();
        m_ready = 1'b1;
        tick();
        check_eq("rd_ack", ack, 2'b10);
        req     = 2'b00;
        m_ready = 1'b0;
        tick();
        check_eq("rd_ack_once", ack, 2'b00);
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEADBEEF;
        tick();
        check_eq("rd_rvalid", rvalid, 2'b10);
        check_eq("rd_rdata", rdata, 32'hDEADBEEF);
        m_rvalid = 1'b0;
        tick();
        check_eq("rd_rvalid_end", rvalid, 2'b00);
        check_eq("rd_rdata_hold", rdata, 32'hDEADBEEF);

        // SPI locks three writes while the CPU keeps asking
        do_reset();
        req     = 2'b11;
        we      = 2'b11;
        lock    = 2'b01;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr[AW-1:0] = AW'(k);
            tick();
            check_eq("lock_owner", {m_valid, owner, m_addr}, {1'b1, 1'b0, AW'(k)});
            tick();
            check_eq("lock_ack", ack, 2'b01);
        end
        lock[0] = 1'b0;
        req[0]  = 1'b0;
        tick();
        check_eq("lock_release", {m_valid, owner}, 2'b11);

        // Reset lands while a read waits in RESP; a late strobe must be ignored
        do_reset();
        req  = 2'b01;
        we   = 2'b00;
        addr = {16'h0000, 16'h0020};
        tick();
        m_ready = 1'b1;
        tick();
        check_eq("rst_pre_busy", busy, 1'b1);
        req     = 2'b00;
        m_ready = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        check_eq("rst_async_ctl", {ack, rvalid, err, m_valid, m_we, owner, busy, m_addr}, 64'd0);
        tick();
        check_eq("rst_async_data", {rdata, m_wdata}, 64'd0);
        clr_n    = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h12345678;
        tick();
        check_eq("rst_late_rvalid", {rvalid, busy}, 3'b000);
        m_rvalid = 1'b0;

`ifdef COPROC_ARB_TIMEOUT_EN
        do_reset();
        req  = 2'b11;
        we   = 2'b11;
        for (int k = 0; k < TO; k++) begin
            tick();
            check_eq("to_valid", m_valid, 1'b1);
        end
        tick();
        check_eq("to_abort", {m_valid, ack, err}, {1'b0, 2'b01, 2'b01});
        req[0] = 1'b0;
        tick();
        check_eq("to_next_grant", {m_valid, owner}, 2'b11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coproc_bus_arbiter.md
# coproc_bus_arbiter

Two-requester arbiter that shares one coprocessor memory-mapped slave (register file / operand RAM) between the SPI-chain bridge master and the soft-CPU data master. It serialises transactions with a round-robin policy and allows one transaction outstanding at a time. It supports a lock for atomic multi-access sequences. It sits between both masters and the shared slave inside the coprocessor top level.

## Interface
- AW, 16, address width
- DW, 32, data width
- TIMEOUT_CYC, 1024, slave watchdog limit in cycles (used only with the watchdog compiled in)

Ports. Index 0 = SPI bridge, index 1 = CPU.
- i_clk  in  1  system clock
- i_clr_n  in  1  reset, asynchronous assert, active-low
- i_req  in  2  per-requester transaction request
- i_we  in  2  per-requester write enable (1 write, 0 read)
- i_addr  in  2*AW  per-requester address, requester n at [n*AW +: AW]
- i_wdata  in  2*DW  per-requester write data
- i_lock  in  2  per-requester lock request
- o_ack  out  2  command accepted by slave, one-cycle pulse
- o_rvalid  out  2  read data valid for requester n, one-cycle pulse
- o_err  out  2  watchdog abort, pulses with o_ack or o_rvalid
- o_rdata  out  DW  read data, qualified by o_rvalid
- o_m_valid  out  1  command valid to slave
- o_m_we  out  1  command write enable
- o_m_addr  out  AW  command address
- o_m_wdata  out  DW  command write data
- i_m_ready  in  1  slave accepts command when high with o_m_valid
- i_m_rvalid  in  1  slave read-data strobe
- i_m_rdata  in  DW  slave read data
- o_owner  out  1  index of current/last granted requester
- o_busy  out  1  high in any state other than IDLE

## Operation
- Reset values: all outputs 0; state IDLE; last-grant register = 1, so requester 0 wins the first tie; lock flag cleared.
- States: IDLE, CMD, RESP.
- IDLE:
  - Pick a requester with i_req=1. On a tie, the requester not granted last wins.
  - If the lock flag is set and i_lock[owner]=1, only the owner can be granted.
  - If i_lock[owner]=0, the lock flag clears in the same cycle and normal round-robin applies.
  - On grant: register we/addr/wdata, set o_owner, set lock flag = i_lock[winner], go to CMD.
- CMD:
  - o_m_valid=1 with the registered command.
  - When i_m_ready=1: pulse o_ack[owner] on the next cycle. A write returns to IDLE. A read goes to RESP.
- RESP:
  - When i_m_rvalid=1, register i_m_rdata into o_rdata and pulse o_rvalid[owner] on the next cycle, then go to IDLE.
- Requesters hold i_req and the command fields stable until o_ack. They must drop i_req, or present a new command, in the cycle o_ack is seen. A request that drops before grant is simply not granted. After grant, the transaction always completes.
- i_m_rvalid outside RESP is ignored.
- o_rdata holds its last value between o_rvalid pulses.

## Timing
- Grant latency: request seen in IDLE -> o_m_valid high on the next cycle.
- Write with ready already high: req(t) -> o_m_valid(t+1) -> o_ack(t+2). IDLE is re-entered at t+2, so the minimum spacing is 2 cycles per write.
- Read: o_rvalid arrives one cycle after i_m_rvalid.
- Lock: while i_lock[owner]=1, the other requester waits indefinitely. No starvation guard beyond the lock.

## Configuration
- COPROC_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to CMD and RESP.
  - On reaching TIMEOUT_CYC in CMD: drop o_m_valid, pulse o_ack[owner] and o_err[owner], go to IDLE.
  - On reaching TIMEOUT_CYC in RESP: pulse o_rvalid[owner] and o_err[owner] with o_rdata=0, go to IDLE.
  - A timeout also clears the lock flag.
  - A late i_m_rvalid is ignored.
- Macro undefined: no counter; waits forever; o_err tied to 0.

## Structure
- Package coproc_arb_pkg holds:
  - state enum (IDLE, CMD, RESP)
  - constants REQ_SPI=0 and REQ_CPU=1
  - default widths
- Sub-module coproc_arb_rr: combinational 2-way round-robin picker. Inputs: req vector, last-grant, lock flag, lock owner. Outputs: grant valid and grant index.

## Test plan
- Simultaneous i_req=2'b11 writes from reset, i_m_ready=1 -> o_ack[0] at cycle 2, then o_ack[1] at cycle 4; o_owner 0 then 1.
- CPU read addr 0x0010; slave ready after 3 cycles, i_m_rvalid 2 cycles after accept with 0xDEADBEEF -> exactly one o_ack[1], then o_rvalid[1] with o_rdata=0xDEADBEEF; o_rvalid[0] stays 0.
- SPI holds i_lock[0]=1 across 3 writes while the CPU requests continuously -> all 3 SPI writes are granted first; the CPU is granted the cycle after i_lock[0] falls.
- Reset asserted in RESP -> next cycle all outputs 0 and state IDLE; a late i_m_rvalid produces no o_rvalid.
- With COPROC_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, i_m_ready held 0 -> o_m_valid drops and o_ack[0] and o_err[0] pulse 8 cycles after CMD entry; the pending CPU request is granted next.
